// File: rtl/serial_pkg.sv
// Shared definitions for the serial-bit source and its sequence detectors.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        GAP   = 2'b10
    } state_t;

    localparam int GAP_CNT_W = 8;

endpackage

// File: rtl/piso_shreg.sv
// Parallel-in / serial-out register, MSB first with zero fill.
module piso_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             sh,
    input  logic [WIDTH-1:0] d,
    output logic             msb
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end else if (sh) begin
            q <= {q[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = q[WIDTH-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Frame transmitter: load a word, shift it out MSB first, then hold idle for GAP cycles.
module serial_pattern_tx
    import serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic             tx_bit,
    output logic             tx_valid,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    state_t               state;
    logic [CW-1:0]        bit_cnt;
    logic [GAP_CNT_W-1:0] gap_cnt;
    logic                 done_q;
    logic                 accept;
    logic                 shifting;
    logic                 msb;

    assign accept   = (state == IDLE) && load;
    assign shifting = (state == SHIFT);

    piso_shreg #(
        .WIDTH(WIDTH)
    ) u_shreg (
        .clk(clk),
        .rst(rst),
        .ld (accept),
        .sh (shifting),
        .d  (data),
        .msb(msb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            gap_cnt <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        bit_cnt <= CW'(WIDTH - 1);
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_cnt == '0) begin
                        done_q <= 1'b1;
                        if (GAP > 0) begin
                            gap_cnt <= GAP_CNT_W'(GAP - 1);
                            state   <= serial_pkg::GAP;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                serial_pkg::GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode straight from flops, so load never reaches them combinationally.
    assign ready    = (state == IDLE);
    assign tx_valid = shifting;
    assign tx_bit   = shifting & msb;
    assign done     = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: three instances share stimulus and are checked against a timing model.
module tb_serial_pattern_tx;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] data;

    logic [2:0] rdy;
    logic [2:0] vld;
    logic [2:0] bt;
    logic [2:0] dn;

    int n_chk;
    int n_fail;
    int cyc;

    int         wv[3] = '{8, 8, 4};
    int         gv[3] = '{0, 2, 0};
    logic       has[3];
    int         fs[3];
    logic [7:0] w[3];

    serial_pattern_tx #(.WIDTH(8), .GAP(0)) u_a (
        .clk(clk), .rst(rst), .load(load), .data(data),
        .ready(rdy[0]), .tx_bit(bt[0]), .tx_valid(vld[0]), .done(dn[0])
    );

    serial_pattern_tx #(.WIDTH(8), .GAP(2)) u_b (
        .clk(clk), .rst(rst), .load(load), .data(data),
        .ready(rdy[1]), .tx_bit(bt[1]), .tx_valid(vld[1]), .done(dn[1])
    );

    serial_pattern_tx #(.WIDTH(4), .GAP(0)) u_c (
        .clk(clk), .rst(rst), .load(load), .data(data[3:0]),
        .ready(rdy[2]), .tx_bit(bt[2]), .tx_valid(vld[2]), .done(dn[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%b want=%b (ready,valid,bit,done)",
                     name, cyc, act, exp);
        end
    endtask

    // Expected {ready,valid,bit,done} from frame start and elapsed cycles.
    function automatic logic [3:0] model_out(int i, int c);
        int   d;
        int   wd;
        logic v;
        logic b;
        logic dd;
        logic r;
        if (!has[i]) return 4'b1000;
        wd = wv[i];
        d  = c - fs[i];
        v  = (d >= 1) && (d <= wd);
        b  = v ? w[i][wd - d] : 1'b0;
        dd = (d == wd + 1);
        r  = (d >= wd + 1 + gv[i]);
        return {r, v, b, dd};
    endfunction

    function automatic logic [3:0] dut_out(int i);
        return {rdy[i], vld[i], bt[i], dn[i]};
    endfunction

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("model_inst%0d", i), dut_out(i), model_out(i, cyc));
        end
    endtask

    task automatic step(input logic ld, input logic [7:0] dt);
        logic [3:0] e;
        check_all();
        load = ld;
        data = dt;
        for (int i = 0; i < 3; i++) begin
            e = model_out(i, cyc);
            if (ld && !rst && e[3]) begin
                has[i] = 1'b1;
                fs[i]  = cyc;
                w[i]   = (wv[i] == 4) ? {4'h0, dt[3:0]} : dt;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) has[i] = 1'b0;
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic       ld;
        logic [7:0] dt;
        logic [3:0] exp;
    } vec_t;

    vec_t       tbl[11];
    int         starts[$];
    logic       prev_v;
    logic [2:0] e4[5];
    int         tot_done;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        load   = 1'b0;
        data   = '0;
        for (int i = 0; i < 3; i++) begin
            has[i] = 1'b0;
            fs[i]  = 0;
            w[i]   = '0;
        end

        tbl[0]  = '{1'b1, 8'hA5, 4'b1000};
        tbl[1]  = '{1'b0, 8'h00, 4'b0110};
        tbl[2]  = '{1'b0, 8'h00, 4'b0100};
        tbl[3]  = '{1'b1, 8'hFF, 4'b0110};
        tbl[4]  = '{1'b1, 8'hFF, 4'b0100};
        tbl[5]  = '{1'b1, 8'hFF, 4'b0100};
        tbl[6]  = '{1'b1, 8'hFF, 4'b0110};
        tbl[7]  = '{1'b0, 8'h00, 4'b0100};
        tbl[8]  = '{1'b0, 8'h00, 4'b0110};
        tbl[9]  = '{1'b0, 8'h00, 4'b1001};
        tbl[10] = '{1'b0, 8'h00, 4'b1000};

        @(negedge clk);
        #1;
        chk("reset_state", dut_out(0), 4'b1000);
        @(negedge clk);
        rst = 1'b0;

        for (int j = 0; j < 5; j++) begin
            chk("idle_after_reset", dut_out(0), 4'b1000);
            step(1'b0, 8'h00);
        end

        // A5 frame with FF loads thrown at it while busy.
        tot_done = 0;
        for (int j = 0; j < 11; j++) begin
            chk($sformatf("table_row%0d", j), dut_out(0), tbl[j].exp);
            tot_done += int'(dn[0]);
            step(tbl[j].ld, tbl[j].dt);
        end
        n_chk++;
        if (tot_done != 1) begin
            n_fail++;
            $display("FAIL done_count got=%0d want=1", tot_done);
        end

        for (int j = 0; j < 14; j++) step(1'b0, 8'h00);

        // Held load on the GAP=2 instance: 11-cycle frame period.
        prev_v = 1'b0;
        for (int j = 0; j < 36; j++) begin
            if (vld[1] && !prev_v) starts.push_back(cyc);
            prev_v = vld[1];
            step(1'b1, 8'hC3);
        end
        n_chk++;
        if (starts.size() < 3 || starts[1] - starts[0] != 11 || starts[2] - starts[1] != 11) begin
            n_fail++;
            $display("FAIL gap_period got=%0d frames, first periods %0d %0d want 11",
                     starts.size(),
                     (starts.size() > 1) ? starts[1] - starts[0] : 0,
                     (starts.size() > 2) ? starts[2] - starts[1] : 0);
        end

        for (int j = 0; j < 14; j++) step(1'b0, 8'h00);

        // Reset during bit 4 of A5, then a clean 3C frame.
        step(1'b1, 8'hA5);
        for (int j = 0; j < 4; j++) step(1'b0, 8'h00);
        chk("pre_reset_bit4", dut_out(0), 4'b0100);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) has[i] = 1'b0;
        #1;
        chk("async_reset", dut_out(0), 4'b1000);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("no_done_after_reset", dut_out(0), 4'b1000);
            step(1'b0, 8'h00);
        end
        step(1'b1, 8'h3C);
        for (int j = 0; j < 12; j++) step(1'b0, 8'h00);

        // WIDTH=4 instance sends 1001.
        e4[0] = 3'b110;
        e4[1] = 3'b100;
        e4[2] = 3'b100;
        e4[3] = 3'b110;
        e4[4] = 3'b001;
        step(1'b1, 8'h09);
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("w4_cycle%0d", j + 1), {1'b0, vld[2], bt[2], dn[2]}, {1'b0, e4[j]});
            step(1'b0, 8'h00);
        end

        for (int j = 0; j < 400; j++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 3) == 0), 8'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Serial pattern transmitter: accepts a WIDTH-bit word through a ready/load handshake and shifts it out MSB-first on a one-bit serial line. It sends one bit per clock, then inserts a programmable idle gap. It is the stimulus end of the serial-bit interface consumed by the team's Moore sequence detectors. It replaces hand-written bit sequences in benches and on-board demos with a synthesizable source.

## Interface
- WIDTH, 8, bits per frame (≥2)
- GAP, 0, idle cycles forced after each frame before ready re-asserts (0–255)
- clk  in  1  system clock, rising-edge active
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- load  in  1  request to start a frame; accepted only when ready=1
- data  in  WIDTH  frame word, sampled on the accepting edge
- ready  out  1  block idle, can accept load
- tx_bit  out  1  serial data, MSB first; 0 whenever tx_valid=0
- tx_valid  out  1  tx_bit carries a frame bit this cycle
- done  out  1  one-cycle pulse after the last bit of a frame

## Operation
- The FSM has three states: IDLE, SHIFT and GAP.
- Reset values: state IDLE, shift register 0, bit counter 0, gap counter 0, ready=1, tx_bit=0, tx_valid=0, done=0.
- IDLE:
  - ready=1.
  - On an edge with load=1, the block captures data into the shift register, sets the bit counter to WIDTH-1 and moves to SHIFT.
- SHIFT:
  - tx_valid=1 and tx_bit = shift register MSB.
  - Each edge shifts the register left with 0 fill and decrements the bit counter.
  - On the edge where the counter is 0 (last bit), done is set for the next cycle.
  - Next state is GAP with the gap counter = GAP-1 if GAP>0; otherwise IDLE.
- GAP:
  - ready=0, tx_valid=0, tx_bit=0.
  - The gap counter decrements each edge and the block returns to IDLE when it reaches 0.
- Load is ignored in SHIFT and GAP. data is not re-sampled; there is no queuing.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- The bit counter is ceil(log2 WIDTH) bits and the gap counter is 8 bits. Neither counter wraps, because state exits before underflow.

## Timing
- Load accepted at edge k:
  - The MSB is on tx_bit during cycle k+1.
  - Bit i (MSB=0) is on tx_bit during cycle k+1+i.
  - The last bit is in cycle k+WIDTH.
- done=1 only during cycle k+WIDTH+1, which is the first non-valid cycle.
- ready:
  - Drops to 0 in cycle k+1.
  - Rises again in cycle k+WIDTH+1+GAP.
- Minimum frame period is WIDTH+1+GAP cycles. There is always at least one tx_valid=0 cycle between frames.
- Reset mid-frame: all outputs are at reset values immediately (asynchronously). The frame is discarded and done is not pulsed.
- If load=1 is held continuously, the block restarts in the same cycle ready is seen as 1. Each accepted load is one frame.
- load coinciding with reset deassertion: the first edge after rst falls may accept it.

## Structure
- Shared package serial_pkg holds:
  - the state enum: IDLE=2'b00, SHIFT=2'b01, GAP=2'b10
  - the constant GAP_CNT_W=8
- The detector side imports the same package.
- Sub-module piso_shreg (WIDTH param; ports clk, rst, ld, sh, d, msb) holds the parallel-in/serial-out register.
- The FSM and both counters live in serial_pattern_tx.

## Test plan
- Reset then idle: rst pulse -> ready=1, tx_valid=0, tx_bit=0, done=0 for 5 cycles with load=0.
- Single frame, WIDTH=8, GAP=0: data=8'hA5, load at edge k -> tx_bit=1,0,1,0,0,1,0,1 in cycles k+1..k+8, tx_valid=1 exactly those cycles, done=1 only at k+9, ready=1 at k+9.
- Load while busy: second load with data=8'hFF during cycles k+3..k+6 -> ignored; serial output still 8'hA5, with only one done pulse.
- Gap, GAP=2, load held high, data=8'hC3 -> frame, then tx_valid=0 for cycles k+9..k+11, next frame's first bit at k+12; frame period is 11 cycles.
- Reset mid-frame: rst asserted during bit 4 of 8'hA5 -> tx_bit/tx_valid go to 0 before the next edge, no done; after release, ready=1 and a new load of 8'h3C transmits correctly.
- WIDTH=4, GAP=0 instance: data=4'b1001 -> tx_bit 1,0,0,1, done 5 cycles after accept. This matches the detector's expected sequence when the two are connected.
